// File: rtl/ascii_line_reader_if.sv
// Pixel input, transmitter handshake and status signals of ascii_line_reader.
// master: pixel source / serial transmitter side. slave: the line reader.
interface ascii_line_reader_if;
  logic       pix_valid;
  logic [7:0] pix_char;
  logic [7:0] tx_data;
  logic       tx_valid;
  logic       tx_ready;
  logic       busy;
  logic       ovf;

  modport master (
    output pix_valid, pix_char, tx_ready,
    input  tx_data, tx_valid, busy, ovf
  );

  modport slave (
    input  pix_valid, pix_char, tx_ready,
    output tx_data, tx_valid, busy, ovf
  );
endinterface

// File: rtl/ascii_line_reader.sv
// ascii_line_reader: samples one ASCII code every DECIM pixels of a video line
// into a ping-pong pair of N-byte banks and streams completed lines out over a
// valid/ready byte interface, followed by a line terminator.
// Build option: define ASCII_LINE_CRLF_EN for a CR+LF terminator; default is LF only.
//
//  state  | meaning
//  IDLE   | no line being sent, waiting for a full bank
//  CHAR   | sending the N characters of the read bank
//  CR     | sending 0x0D (only with ASCII_LINE_CRLF_EN)
//  LF     | sending 0x0A, bank released on transfer
module ascii_line_reader #(
  parameter int LINE_W = 640,
  parameter int DECIM  = 8
) (
  input  logic clk,
  input  logic rst_n,
  ascii_line_reader_if.slave bus
);
  localparam int N      = LINE_W / DECIM;
  localparam int X_W    = (LINE_W > 1) ? $clog2(LINE_W) : 1;
  localparam int IDX_W  = (N > 1) ? $clog2(N) : 1;
  localparam int DEC_SH = $clog2(DECIM);

  typedef enum logic [1:0] {S_IDLE, S_CHAR, S_CR, S_LF} state_t;

  logic [7:0]       r_mem [2][N];
  logic [X_W-1:0]   r_x;
  logic             r_sync;
  logic             r_wbank;
  logic             r_rbank;
  logic [1:0]       r_full;
  logic             r_ovf;
  state_t           r_state;
  logic [IDX_W-1:0] r_idx;
  logic [7:0]       r_tx_data;
  logic             r_tx_valid;

  logic             w_pix_ok;
  logic             w_last;
  logic             w_sample;
  logic [IDX_W-1:0] w_wr_idx;
  logic [7:0]       w_char_map;
  logic             w_xfer;
  logic             w_release;
  logic             w_wbank_free;
  logic [1:0]       w_full_nxt;
  logic [IDX_W-1:0] w_idx_nxt;

  // r_sync stays low after reset until pix_valid has been seen low, so a line
  // already in flight at reset is ignored instead of being picked up mid-way.
  assign w_pix_ok   = bus.pix_valid && r_sync;
  assign w_last     = w_pix_ok && (r_x == X_W'(LINE_W - 1));
  assign w_sample   = w_pix_ok && ((r_x & X_W'(DECIM - 1)) == '0);
  assign w_wr_idx   = IDX_W'(r_x >> DEC_SH);
  assign w_char_map = ((bus.pix_char >= 8'h20) && (bus.pix_char <= 8'h7E)) ? bus.pix_char : 8'h3F;
  assign w_xfer     = r_tx_valid && bus.tx_ready;
  assign w_release  = w_xfer && (r_state == S_LF);
  assign w_idx_nxt  = r_idx + IDX_W'(1);

  // A bank being released this very cycle counts as free. When both banks hold
  // unsent lines the write bank points at a full bank: writes are blocked and the
  // incoming line is dropped at completion.
  assign w_wbank_free = !r_full[r_wbank] || (w_release && (r_rbank == r_wbank));

  // Next bank-full flags: release by the reader, then capture of a completed line.
  always_comb begin
    w_full_nxt = r_full;
    if (w_release) w_full_nxt[r_rbank] = 1'b0;
    if (w_last && w_wbank_free) w_full_nxt[r_wbank] = 1'b1;
  end

  // Line buffer write; contents are don't-care after reset.
  always_ff @(posedge clk) begin
    if (w_sample && w_wbank_free) r_mem[r_wbank][w_wr_idx] <= w_char_map;
  end

  // Pixel counter, bank ownership and overflow pulse.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_x     <= '0;
      r_sync  <= 1'b0;
      r_wbank <= 1'b0;
      r_full  <= 2'b00;
      r_ovf   <= 1'b0;
    end else begin
      r_ovf  <= 1'b0;
      r_full <= w_full_nxt;
      if (!bus.pix_valid) begin
        r_x    <= '0;
        r_sync <= 1'b1;
      end else if (!r_sync || w_last) begin
        r_x <= '0;
      end else begin
        r_x <= r_x + X_W'(1);
      end
      if (w_last) begin
        if (w_wbank_free) r_wbank <= ~r_wbank;
        else              r_ovf   <= 1'b1;
      end
    end
  end

  // Read FSM with registered tx outputs; the first byte is loaded one cycle after
  // leaving IDLE, then each transfer loads the next byte with no bubble.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state    <= S_IDLE;
      r_idx      <= '0;
      r_rbank    <= 1'b0;
      r_tx_data  <= 8'h00;
      r_tx_valid <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          r_tx_valid <= 1'b0;
          if (r_full[r_rbank]) begin
            r_state <= S_CHAR;
            r_idx   <= '0;
          end
        end
        S_CHAR: begin
          if (!r_tx_valid) begin
            r_tx_data  <= r_mem[r_rbank][r_idx];
            r_tx_valid <= 1'b1;
          end else if (bus.tx_ready) begin
            if (r_idx == IDX_W'(N - 1)) begin
`ifdef ASCII_LINE_CRLF_EN
              r_state   <= S_CR;
              r_tx_data <= 8'h0D;
`else
              r_state   <= S_LF;
              r_tx_data <= 8'h0A;
`endif
            end else begin
              r_idx     <= w_idx_nxt;
              r_tx_data <= r_mem[r_rbank][w_idx_nxt];
            end
          end
        end
        S_CR: begin
          if (w_xfer) begin
            r_state   <= S_LF;
            r_tx_data <= 8'h0A;
          end
        end
        S_LF: begin
          if (w_xfer) begin
            r_tx_valid <= 1'b0;
            r_rbank    <= ~r_rbank;
            r_idx      <= '0;
            r_state    <= r_full[~r_rbank] ? S_CHAR : S_IDLE;
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign bus.tx_data  = r_tx_data;
  assign bus.tx_valid = r_tx_valid;
  assign bus.ovf      = r_ovf;
  assign bus.busy     = (r_state != S_IDLE) || (|r_full);
endmodule

// File: tb/tb_ascii_line_reader.sv
// Testbench for ascii_line_reader: directed steps with a byte scoreboard.
// Works for both the LF-only and the ASCII_LINE_CRLF_EN builds.
module tb_ascii_line_reader;
  localparam int LINE_W = 640;
  localparam int DECIM  = 8;
  localparam int N      = LINE_W / DECIM;
`ifdef ASCII_LINE_CRLF_EN
  localparam int TERM = 2;
`else
  localparam int TERM = 1;
`endif

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  ascii_line_reader_if bus ();

  ascii_line_reader #(.LINE_W(LINE_W), .DECIM(DECIM)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus.slave)
  );

  int vectors = 0;
  int miscompares = 0;
  logic [7:0] exp_q [$];
  logic [7:0] line_chars [N];
  int n_bytes = 0;
  int n_ovf = 0;
  int ready_mode = 0;
  logic ready_hold = 1'b1;
  int cyc = 0;

  function automatic logic [7:0] map_char(input logic [7:0] b);
    return (b >= 8'h20 && b <= 8'h7E) ? b : 8'h3F;
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // 0: 'A'..'Z' repeating, 1: same with control codes in chars 0 and 1, 2: random
  task automatic fill_chars(input int mode);
    for (int i = 0; i < N; i++) line_chars[i] = 8'h41 + 8'(i % 26);
    if (mode == 1) begin
      line_chars[0] = 8'h07;
      line_chars[1] = 8'h7F;
    end else if (mode == 2) begin
      for (int i = 0; i < N; i++) line_chars[i] = 8'($urandom_range(0, 255));
    end
  endtask

  task automatic push_line();
    for (int i = 0; i < N; i++) exp_q.push_back(map_char(line_chars[i]));
`ifdef ASCII_LINE_CRLF_EN
    exp_q.push_back(8'h0D);
`endif
    exp_q.push_back(8'h0A);
  endtask

  // Drives nlines back-to-back lines of len pixels; the first nkeep complete lines
  // are expected on the output. Returns 1 time unit after the last pixel edge.
  task automatic drive_lines(input int nlines, input int nkeep, input int len, input bit junk);
    for (int l = 0; l < nlines; l++) begin
      if (l < nkeep && len == LINE_W) push_line();
      for (int x = 0; x < len; x++) begin
        bus.pix_valid = 1'b1;
        if (junk && (x % DECIM) != 0) bus.pix_char = 8'($urandom_range(0, 255));
        else                          bus.pix_char = line_chars[x / DECIM];
        @(posedge clk); #1;
      end
    end
    bus.pix_valid = 1'b0;
  endtask

  task automatic cycles(input int n);
    repeat (n) begin @(posedge clk); #1; end
  endtask

  task automatic wait_drain();
    int t = 0;
    while ((exp_q.size() != 0 || bus.busy) && t < 20000) begin
      @(posedge clk); #1;
      t++;
    end
    check("drain_timeout", 32'(t < 20000), 32'd1);
    check("drain_queue_empty", 32'(exp_q.size()), 32'd0);
  endtask

  // Transmitter side: tx_ready pattern selected by ready_mode.
  initial begin
    bus.tx_ready = 1'b1;
    forever begin
      @(posedge clk); #1;
      cyc++;
      case (ready_mode)
        0:       bus.tx_ready = ready_hold;
        1:       bus.tx_ready = (cyc % 3 == 0);
        default: bus.tx_ready = 1'($urandom_range(0, 1));
      endcase
    end
  end

  // Output monitor: scoreboard pop on each transfer, stall stability, ovf count.
  initial begin
    logic prev_stall;
    logic [7:0] stall_data;
    logic [7:0] exp;
    prev_stall = 1'b0;
    stall_data = 8'h00;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        prev_stall = 1'b0;
      end else begin
        if (prev_stall) begin
          check("stall_valid_held", 32'(bus.tx_valid), 32'd1);
          check("stall_data_held", 32'(bus.tx_data), 32'(stall_data));
        end
        if (bus.tx_valid && bus.tx_ready) begin
          n_bytes++;
          if (exp_q.size() == 0) begin
            vectors++;
            miscompares++;
            $error("FAIL unexpected_byte: observed %0h expected none", bus.tx_data);
          end else begin
            exp = exp_q.pop_front();
            check("tx_byte", 32'(bus.tx_data), 32'(exp));
          end
        end
        prev_stall = bus.tx_valid && !bus.tx_ready;
        stall_data = bus.tx_data;
        if (bus.ovf) n_ovf++;
      end
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int b0;
    int o0;
    rst_n = 1'b0;
    bus.pix_valid = 1'b0;
    bus.pix_char = 8'h00;
    cycles(3);
    check("rst_tx_valid", 32'(bus.tx_valid), 32'd0);
    check("rst_tx_data", 32'(bus.tx_data), 32'h00);
    check("rst_busy", 32'(bus.busy), 32'd0);
    check("rst_ovf", 32'(bus.ovf), 32'd0);
    rst_n = 1'b1;
    cycles(3);

    // One line, tx_ready high: latency and contents.
    fill_chars(0);
    b0 = n_bytes;
    drive_lines(1, 1, LINE_W, 1'b0);
    check("lat_e0_valid", 32'(bus.tx_valid), 32'd0);
    check("lat_e0_busy", 32'(bus.busy), 32'd1);
    cycles(1);
    check("lat_e1_valid", 32'(bus.tx_valid), 32'd0);
    cycles(1);
    check("lat_e2_valid", 32'(bus.tx_valid), 32'd1);
    check("lat_e2_data", 32'(bus.tx_data), 32'h41);
    wait_drain();
    check("line1_count", 32'(n_bytes - b0), 32'(N + TERM));

    // tx_ready high one cycle in three.
    ready_mode = 1;
    b0 = n_bytes;
    drive_lines(1, 1, LINE_W, 1'b0);
    wait_drain();
    check("stall_count", 32'(n_bytes - b0), 32'(N + TERM));
    ready_mode = 0;

    // tx_ready low, three back-to-back lines: third is dropped.
    ready_hold = 1'b0;
    cycles(2);
    b0 = n_bytes;
    o0 = n_ovf;
    drive_lines(3, 2, LINE_W, 1'b0);
    check("ovf_pulse_hi", 32'(bus.ovf), 32'd1);
    cycles(1);
    check("ovf_pulse_lo", 32'(bus.ovf), 32'd0);
    check("ovf_count", 32'(n_ovf - o0), 32'd1);
    check("held_valid", 32'(bus.tx_valid), 32'd1);
    check("held_data", 32'(bus.tx_data), 32'h41);
    ready_hold = 1'b1;
    wait_drain();
    check("two_line_count", 32'(n_bytes - b0), 32'(2 * (N + TERM)));

    // Partial line: nothing sent, no ovf; then a line with control codes.
    b0 = n_bytes;
    o0 = n_ovf;
    drive_lines(1, 0, 300, 1'b0);
    cycles(10);
    check("partial_busy", 32'(bus.busy), 32'd0);
    check("partial_bytes", 32'(n_bytes - b0), 32'd0);
    check("partial_ovf", 32'(n_ovf - o0), 32'd0);
    fill_chars(1);
    drive_lines(1, 1, LINE_W, 1'b0);
    wait_drain();
    check("ctrl_count", 32'(n_bytes - b0), 32'(N + TERM));

    // Random characters with junk between samples and random tx_ready.
    fill_chars(2);
    ready_mode = 2;
    drive_lines(1, 1, LINE_W, 1'b1);
    wait_drain();
    ready_mode = 0;

    // Reset while a line is transmitting and another is being written.
    ready_hold = 1'b0;
    fill_chars(0);
    drive_lines(1, 1, LINE_W, 1'b0);
    cycles(5);
    check("pre_rst_valid", 32'(bus.tx_valid), 32'd1);
    for (int x = 0; x < 200; x++) begin
      bus.pix_valid = 1'b1;
      bus.pix_char = line_chars[x / DECIM];
      @(posedge clk); #1;
    end
    #2 rst_n = 1'b0;
    #1;
    check("rst_mid_valid", 32'(bus.tx_valid), 32'd0);
    check("rst_mid_busy", 32'(bus.busy), 32'd0);
    exp_q.delete();
    cycles(3);
    rst_n = 1'b1;
    ready_hold = 1'b1;
    b0 = n_bytes;
    for (int x = 200; x < LINE_W; x++) begin
      bus.pix_valid = 1'b1;
      bus.pix_char = line_chars[x / DECIM];
      @(posedge clk); #1;
    end
    bus.pix_valid = 1'b0;
    cycles(10);
    check("lost_line_busy", 32'(bus.busy), 32'd0);
    check("lost_line_bytes", 32'(n_bytes - b0), 32'd0);
    drive_lines(1, 1, LINE_W, 1'b0);
    wait_drain();
    check("post_rst_count", 32'(n_bytes - b0), 32'(N + TERM));

    cycles(5);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
